game_flow_ctrl: RTL and testbench

Parametrised successor to the 3-state game FSM in the VGA top level. It sequences a multi-level boss game: MENU, COUNTDOWN, PLAY, PAUSE, LEVEL_CLEAR, GAME_OVER and VICTORY. Countdowns and play time are measured in frames, derived from vsync. Outputs drive the existing game_active and menu/end-screen consumers, plus new level and countdown overlays.

---
 rtl/game_flow_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer for the multi-level boss game: menu, countdown, play, pause,
// level clear and the two end screens, with all timing measured in vsync frames.
module game_flow_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int HP_W             = 4,
  parameter int BOSS_HP_W        = 7,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int CLEAR_FRAMES     = 120,
  parameter int TIME_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync_in,
  input  logic                 game_start,
  input  logic                 back_to_menu,
  input  logic                 pause_req,
  input  logic [HP_W-1:0]      current_health,
  input  logic [BOSS_HP_W-1:0] boss_hp,
  output logic [2:0]           state,
  output logic [1:0]           game_state,
  output logic                 game_active,
  output logic                 show_menu_end,
  output logic [3:0]           level,
  output logic                 level_start,
  output logic [7:0]           countdown,
  output logic [TIME_W-1:0]    play_frames
);

  typedef enum logic [2:0] {
    S_MENU        = 3'd0,
    S_COUNTDOWN   = 3'd1,
    S_PLAY        = 3'd2,
    S_PAUSE       = 3'd3,
    S_LEVEL_CLEAR = 3'd4,
    S_GAME_OVER   = 3'd5,
    S_VICTORY     = 3'd6
  } state_e;

  // Counter is at least 8 bits so the 255 saturation compare is always well formed.
  localparam int CNT_MAX  = (COUNTDOWN_FRAMES > CLEAR_FRAMES) ? COUNTDOWN_FRAMES : CLEAR_FRAMES;
  localparam int CNT_BITS = $clog2(CNT_MAX + 1);
  localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;

  localparam logic [CNT_W-1:0] CD_LOAD    = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLEAR_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(255);
  localparam logic [3:0]       LAST_LEVEL = 4'(NUM_LEVELS - 1);

  state_e             st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         level_q, level_d;
  logic [TIME_W-1:0]  pf_q;
  logic               vsync_q;
  logic               ls_q;
  logic               tick;
  logic               enter_cd;

  assign tick = vsync_in & ~vsync_q;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    enter_cd = 1'b0;

    if (back_to_menu && st_q != S_MENU) begin
      st_d    = S_MENU;
      level_d = 4'd0;
      cnt_d   = '0;
    end else begin
      unique case (st_q)
        S_MENU, S_GAME_OVER, S_VICTORY: begin
          if (game_start) begin
            st_d     = S_COUNTDOWN;
            level_d  = 4'd0;
            cnt_d    = CD_LOAD;
            enter_cd = 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (tick) begin
            if (cnt_q == CNT_ONE) begin
              st_d  = S_PLAY;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        S_PLAY: begin
          if (current_health == '0) begin
            st_d = S_GAME_OVER;
          end else if (boss_hp == '0 && level_q == LAST_LEVEL) begin
            st_d = S_VICTORY;
          end else if (boss_hp == '0) begin
            st_d  = S_LEVEL_CLEAR;
            cnt_d = CLR_LOAD;
          end else if (pause_req) begin
            st_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (pause_req) st_d = S_PLAY;
        end
        S_LEVEL_CLEAR: begin
          if (tick) begin
            if (cnt_q == CNT_ONE) begin
              st_d     = S_COUNTDOWN;
              level_d  = level_q + 4'd1;
              cnt_d    = CD_LOAD;
              enter_cd = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          st_d    = S_MENU;
          level_d = 4'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_MENU;
      cnt_q   <= '0;
      level_q <= 4'd0;
      pf_q    <= '0;
      vsync_q <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      vsync_q <= vsync_in;
      ls_q    <= enter_cd;
      // Play time only advances while PLAY is held across the tick.
      if (enter_cd) begin
        pf_q <= '0;
      end else if (st_q == S_PLAY && st_d == S_PLAY && tick && pf_q != '1) begin
        pf_q <= pf_q + 1'b1;
      end
    end
  end

  assign state         = st_q;
  assign level         = level_q;
  assign level_start   = ls_q;
  assign play_frames   = pf_q;
  assign game_active   = (st_q == S_PLAY);
  assign show_menu_end = (st_q == S_MENU) || (st_q == S_GAME_OVER) || (st_q == S_VICTORY);
  assign game_state    = (st_q == S_MENU) ? 2'd0 :
                         ((st_q == S_GAME_OVER) || (st_q == S_VICTORY)) ? 2'd2 : 2'd1;
  assign countdown     = (st_q == S_COUNTDOWN || st_q == S_LEVEL_CLEAR) ?
                         ((cnt_q > CNT_SAT) ? 8'hFF : cnt_q[7:0]) : 8'd0;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: the driver queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_flow_ctrl;

  localparam int NUM_LEVELS = 3;
  localparam int HP_W       = 4;
  localparam int BOSS_HP_W  = 7;
  localparam int CD_FRAMES  = 3;
  localparam int CLR_FRAMES = 2;
  localparam int TIME_W     = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 vsync_in = 1'b0;
  logic                 game_start = 1'b0;
  logic                 back_to_menu = 1'b0;
  logic                 pause_req = 1'b0;
  logic [HP_W-1:0]      current_health = 4'd8;
  logic [BOSS_HP_W-1:0] boss_hp = 7'd50;
  logic [2:0]           state;
  logic [1:0]           game_state;
  logic                 game_active;
  logic                 show_menu_end;
  logic [3:0]           level;
  logic                 level_start;
  logic [7:0]           countdown;
  logic [TIME_W-1:0]    play_frames;

  game_flow_ctrl #(
    .NUM_LEVELS(NUM_LEVELS), .HP_W(HP_W), .BOSS_HP_W(BOSS_HP_W),
    .COUNTDOWN_FRAMES(CD_FRAMES), .CLEAR_FRAMES(CLR_FRAMES), .TIME_W(TIME_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .game_start(game_start),
    .back_to_menu(back_to_menu), .pause_req(pause_req),
    .current_health(current_health), .boss_hp(boss_hp),
    .state(state), .game_state(game_state), .game_active(game_active),
    .show_menu_end(show_menu_end), .level(level), .level_start(level_start),
    .countdown(countdown), .play_frames(play_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [3:0] lvl;
    logic [7:0] cd;
    logic [15:0] pf;
    logic       ls;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected snapshot of the outputs as they stand right now (compared at next negedge).
  task automatic expect_out(input string name, input logic [2:0] st, input logic [3:0] lvl,
                            input logic [7:0] cd, input logic [15:0] pf, input logic ls);
    exp_t e;
    e.name = name; e.st = st; e.lvl = lvl; e.cd = cd; e.pf = pf; e.ls = ls;
    exp_q.push_back(e);
  endtask

  // Monitor: every negedge, compare all pending expectations.
  initial begin
    exp_t e;
    logic [1:0] gs;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        gs = (e.st == 3'd0) ? 2'd0 : ((e.st == 3'd5 || e.st == 3'd6) ? 2'd2 : 2'd1);
        check({e.name, ".state"},       32'(state),         32'(e.st));
        check({e.name, ".level"},       32'(level),         32'(e.lvl));
        check({e.name, ".countdown"},   32'(countdown),     32'(e.cd));
        check({e.name, ".play_frames"}, 32'(play_frames),   32'(e.pf));
        check({e.name, ".level_start"}, 32'(level_start),   32'(e.ls));
        check({e.name, ".game_active"}, 32'(game_active),   32'(e.st == 3'd2));
        check({e.name, ".menu_end"},    32'(show_menu_end), 32'(e.st == 3'd0 || e.st == 3'd5 || e.st == 3'd6));
        check({e.name, ".game_state"},  32'(game_state),    32'(gs));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync_in = 1'b1; cyc(1);
    vsync_in = 1'b0; cyc(1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    game_start = 1'b1; cyc(1); game_start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_req = 1'b1; cyc(1); pause_req = 1'b0;
  endtask

  task automatic kill_boss();
    boss_hp = 7'd0; cyc(1); boss_hp = 7'd50;
  endtask

  // From MENU/end screen: start and walk to PLAY at level 2.
  task automatic reach_level2_play();
    pulse_start();
    frames(CD_FRAMES);
    kill_boss(); frames(CLR_FRAMES);
    frames(CD_FRAMES);
    kill_boss(); frames(CLR_FRAMES);
    frames(CD_FRAMES);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    expect_out("reset", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);

    pulse_pause();
    expect_out("pause_in_menu", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);

    pulse_start();
    expect_out("start_pulse", 3'd1, 4'd0, 8'd3, 16'd0, 1'b1);
    cyc(1);
    expect_out("start_pulse_end", 3'd1, 4'd0, 8'd3, 16'd0, 1'b0);

    pulse_pause();
    expect_out("pause_in_cd", 3'd1, 4'd0, 8'd3, 16'd0, 1'b0);
    pulse_start();
    expect_out("start_in_cd", 3'd1, 4'd0, 8'd3, 16'd0, 1'b0);

    frame(); expect_out("cd_2", 3'd1, 4'd0, 8'd2, 16'd0, 1'b0);
    frame(); expect_out("cd_1", 3'd1, 4'd0, 8'd1, 16'd0, 1'b0);
    frame(); expect_out("play_entry", 3'd2, 4'd0, 8'd0, 16'd0, 1'b0);

    frames(10);
    expect_out("pf_10", 3'd2, 4'd0, 8'd0, 16'd10, 1'b0);
    pulse_pause();
    expect_out("paused", 3'd3, 4'd0, 8'd0, 16'd10, 1'b0);
    current_health = 4'd0;
    frames(5);
    expect_out("pause_frozen", 3'd3, 4'd0, 8'd0, 16'd10, 1'b0);
    current_health = 4'd8;
    pulse_pause();
    expect_out("resume", 3'd2, 4'd0, 8'd0, 16'd10, 1'b0);
    frame();
    expect_out("pf_11", 3'd2, 4'd0, 8'd0, 16'd11, 1'b0);

    kill_boss();
    expect_out("level_clear", 3'd4, 4'd0, 8'd2, 16'd11, 1'b0);
    frame();
    expect_out("clear_1", 3'd4, 4'd0, 8'd1, 16'd11, 1'b0);
    vsync_in = 1'b1; cyc(1);
    expect_out("level1_start", 3'd1, 4'd1, 8'd3, 16'd0, 1'b1);
    vsync_in = 1'b0; cyc(1);
    expect_out("level1_cd", 3'd1, 4'd1, 8'd3, 16'd0, 1'b0);

    frames(CD_FRAMES);
    pulse_pause();
    expect_out("l1_paused", 3'd3, 4'd1, 8'd0, 16'd0, 1'b0);
    back_to_menu = 1'b1; cyc(1); back_to_menu = 1'b0;
    expect_out("menu_from_pause", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);

    reach_level2_play();
    expect_out("level2_play", 3'd2, 4'd2, 8'd0, 16'd0, 1'b0);
    boss_hp = 7'd0; current_health = 4'd0; cyc(1);
    boss_hp = 7'd50; current_health = 4'd8;
    expect_out("defeat_wins", 3'd5, 4'd2, 8'd0, 16'd0, 1'b0);
    cyc(2);
    expect_out("game_over_hold", 3'd5, 4'd2, 8'd0, 16'd0, 1'b0);

    // Restart with a coincident tick: reload wins, no decrement.
    game_start = 1'b1; vsync_in = 1'b1; cyc(1);
    game_start = 1'b0;
    expect_out("restart_tick", 3'd1, 4'd0, 8'd3, 16'd0, 1'b1);
    vsync_in = 1'b0; cyc(1);
    expect_out("restart_cd", 3'd1, 4'd0, 8'd3, 16'd0, 1'b0);

    back_to_menu = 1'b1; cyc(1); back_to_menu = 1'b0;
    reach_level2_play();
    kill_boss();
    expect_out("victory", 3'd6, 4'd2, 8'd0, 16'd0, 1'b0);
    game_start = 1'b1; back_to_menu = 1'b1; cyc(1);
    game_start = 1'b0; back_to_menu = 1'b0;
    expect_out("btm_over_start", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);

    pulse_start();
    frame();
    expect_out("pre_reset_cd", 3'd1, 4'd0, 8'd2, 16'd0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    expect_out("post_reset_1", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);
    cyc(1);
    expect_out("post_reset_2", 3'd0, 4'd0, 8'd0, 16'd0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
